vga_pll_supervisor: RTL and testbench



---
 rtl/vga_pll_sup_pkg.sv | 22 ++
 rtl/vga_pll_supervisor_if.sv | 36 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/vga_pll_supervisor.sv | 126 ++++++++++++
 tb/tb_vga_pll_supervisor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pll_sup_pkg.sv
// Shared state encoding and counter sizing helper for the VGA pixel-PLL supervisor.
package vga_pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } sup_state_t;

    // Counter only has to reach (largest interval - 1); never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/vga_pll_supervisor_if.sv
// Signal bundle between the supervisor, the pixel PLL and the pixel pipeline.
// Optional loss_cnt exists only when VGA_PLL_SUP_LOSS_CNT_EN is defined.
interface vga_pll_supervisor_if #(
    parameter int unsigned MAX_RETRIES = 3
) ();
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    logic          locked;
    logic          retry_req;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          lock_fail;
    logic [RW-1:0] retries;
`ifdef VGA_PLL_SUP_LOSS_CNT_EN
    logic [7:0]    loss_cnt;

    modport master (
        input  locked, retry_req,
        output pll_rst, sys_rst_n, ready, lock_fail, retries, loss_cnt
    );
    modport slave (
        output locked, retry_req,
        input  pll_rst, sys_rst_n, ready, lock_fail, retries, loss_cnt
    );
`else
    modport master (
        input  locked, retry_req,
        output pll_rst, sys_rst_n, ready, lock_fail, retries
    );
    modport slave (
        output locked, retry_req,
        input  pll_rst, sys_rst_n, ready, lock_fail, retries
    );
`endif
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/vga_pll_supervisor.sv
// Pixel-PLL reset/lock sequencer: pulses pll_rst, debounces lock, releases sys_rst_n.
// Define VGA_PLL_SUP_LOSS_CNT_EN to add the saturating lock-loss counter (loss_cnt).
module vga_pll_supervisor
    import vga_pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input logic                  refclk,
    input logic                  rst_n,
    vga_pll_supervisor_if.master sup
);
    localparam int unsigned CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    localparam logic [2:0] ST_RESET     = RESET;
    localparam logic [2:0] ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [2:0] ST_STABLE    = STABLE;
    localparam logic [2:0] ST_RUN       = RUN;
    localparam logic [2:0] ST_FAIL      = FAIL;

    logic          locked_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retries_q, retries_d, retries_inc;
    logic          pll_rst_q, sys_rst_n_q, ready_q, lock_fail_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (sup.locked),
        .q_o    (locked_s)
    );

    assign retries_inc = retries_q + RW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        retries_d = retries_q;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = ST_RUN;
                    retries_d = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s) state_d = ST_RESET;
            end
            ST_FAIL: begin
                if (sup.retry_req) begin
                    state_d   = ST_RESET;
                    retries_d = '0;
                end
            end
            default: state_d = ST_RESET;
        endcase
        // Counter only measures time within a timed state, so it never wraps.
        if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAIL) cnt_d = '0;
    end

    // Outputs are flopped decodes of the next state, so they track state_q glitch-free.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retries_q   <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            lock_fail_q <= (state_d == ST_FAIL);
        end
    end

    assign sup.pll_rst   = pll_rst_q;
    assign sup.sys_rst_n = sys_rst_n_q;
    assign sup.ready     = ready_q;
    assign sup.lock_fail = lock_fail_q;
    assign sup.retries   = retries_q;

`ifdef VGA_PLL_SUP_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if (state_q == ST_RUN && !locked_s && loss_cnt_q != 8'hff) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign sup.loss_cnt = loss_cnt_q;
`endif
endmodule

// File: tb/tb_vga_pll_supervisor.sv
// Event-scoreboard bench for vga_pll_supervisor: expected output changes are queued with
// their cycle when stimulus is applied, and matched against observed changes on negedge.
module tb_vga_pll_supervisor;
    localparam logic [5:0] V_RESET0 = 6'b100000;
    localparam logic [5:0] V_RESET1 = 6'b100001;
    localparam logic [5:0] V_WAIT0  = 6'b000000;
    localparam logic [5:0] V_WAIT1  = 6'b000001;
    localparam logic [5:0] V_RUN    = 6'b011000;
    localparam logic [5:0] V_FAIL   = 6'b100110;

    typedef struct {
        string       tag;
        int unsigned cyc;
        logic [5:0]  val;
    } exp_t;

    logic        refclk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_errors;
    exp_t        exp_q[$];
    logic [5:0]  prev;
    logic [5:0]  obs;
`ifdef VGA_PLL_SUP_LOSS_CNT_EN
    int unsigned exp_loss;
`endif

    vga_pll_supervisor_if #(.MAX_RETRIES(2)) sup ();

    vga_pll_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (100),
        .STABLE_CYC       (8),
        .MAX_RETRIES      (2)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .sup    (sup.master)
    );

    assign obs = {sup.pll_rst, sup.sys_rst_n, sup.ready, sup.lock_fail, sup.retries};

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Observed output changes are matched in order against the expected-event queue.
    always @(negedge refclk) begin
        if (rst_n && obs !== prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", 32'(obs), 32'(prev));
            end else begin
                check({exp_q[0].tag, "_val"}, 32'(obs), 32'(exp_q[0].val));
                check({exp_q[0].tag, "_cyc"}, cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
        prev <= obs;
    end

    task automatic tick();
        @(posedge refclk);
        #2;
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic push(input string tag, input int unsigned c, input logic [5:0] v);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_loss();
`ifdef VGA_PLL_SUP_LOSS_CNT_EN
        check("loss_cnt", 32'(sup.loss_cnt), exp_loss);
`endif
    endtask

    task automatic check_reset_vals(input string where);
        check({where, "_pll_rst"}, 32'(sup.pll_rst), 1);
        check({where, "_sys_rst_n"}, 32'(sup.sys_rst_n), 0);
        check({where, "_ready"}, 32'(sup.ready), 0);
        check({where, "_lock_fail"}, 32'(sup.lock_fail), 0);
        check({where, "_retries"}, 32'(sup.retries), 0);
    endtask

    task automatic release_reset(input bit expect_run);
        tick();
        rst_n = 1'b1;
        push("rel_wait", cyc + 4, V_WAIT0);
        // With lock already high, locked_s is ready the first WAIT_LOCK cycle.
        if (expect_run) push("rel_run", cyc + 13, V_RUN);
    endtask

    task automatic hit_reset(input string where);
        rst_n = 1'b0;
        #1;
        check_reset_vals(where);
        exp_q.delete();
`ifdef VGA_PLL_SUP_LOSS_CNT_EN
        exp_loss = 0;
`endif
        wait_cyc(3);
    endtask

    task automatic lock_up();
        sup.locked = 1'b1;
        push("lock_run", cyc + 11, V_RUN);
    endtask

    task automatic lock_drop();
        sup.locked = 1'b0;
`ifdef VGA_PLL_SUP_LOSS_CNT_EN
        exp_loss++;
`endif
        push("loss_rst", cyc + 3, V_RESET0);
        push("loss_wait", cyc + 7, V_WAIT0);
    endtask

    initial begin
        int unsigned f;
        cyc           = 0;
        n_checks      = 0;
        n_errors      = 0;
        prev          = V_RESET0;
        rst_n         = 1'b0;
        sup.locked    = 1'b0;
        sup.retry_req = 1'b0;
`ifdef VGA_PLL_SUP_LOSS_CNT_EN
        exp_loss      = 0;
`endif
        wait_cyc(3);
        check_reset_vals("por");

        // Nominal lock
        release_reset(1'b0);
        wait_cyc(20);
        lock_up();
        drain(100);
        check_loss();

        // Lock loss in RUN, then re-lock
        lock_drop();
        wait_cyc(10);
        lock_up();
        drain(100);
        check_loss();

        // Glitchy lock: 5 high, 1 low, then high
        lock_drop();
        wait_cyc(10);
        sup.locked = 1'b1;
        wait_cyc(5);
        sup.locked = 1'b0;
        tick();
        sup.locked = 1'b1;
        push("glitch_run", cyc + 11, V_RUN);
        drain(100);

        // Lock arriving on the last WAIT_LOCK cycle beats the timeout
        lock_drop();
        wait_cyc(104);
        sup.locked = 1'b1;
        push("late_run", cyc + 11, V_RUN);
        drain(150);
        check_loss();

        // Two timeouts into FAIL, then retry_req
        lock_drop();
        push("to_rst1", cyc + 107, V_RESET1);
        push("to_wait1", cyc + 111, V_WAIT1);
        push("to_fail", cyc + 211, V_FAIL);
        drain(300);
        wait_cyc(5);
        check("fail_lock_fail", 32'(sup.lock_fail), 1);
        check("fail_pll_rst", 32'(sup.pll_rst), 1);
        check("fail_retries", 32'(sup.retries), 2);
        sup.retry_req = 1'b1;
        push("retry_rst", cyc + 1, V_RESET0);
        push("retry_wait", cyc + 5, V_WAIT0);
        tick();
        sup.retry_req = 1'b0;
        drain(20);

        // Reset asserted while in STABLE
        sup.locked = 1'b1;
        wait_cyc(4);
        hit_reset("rst_stable");
        release_reset(1'b1);
        drain(50);

        // Reset asserted while in RUN
        wait_cyc(5);
        hit_reset("rst_run");
        release_reset(1'b1);
        drain(50);
        check_loss();

        // retry_req in RUN is ignored
        sup.retry_req = 1'b1;
        tick();
        sup.retry_req = 1'b0;
        wait_cyc(10);
        check("run_ready_after_req", 32'(sup.ready), 1);
        check("run_pll_rst_after_req", 32'(sup.pll_rst), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
